// File: rtl/fpu_arith_arbiter.sv
// Round-robin arbiter sharing one FPU arithmetic unit between two sequencers.
// Optional WAIT watchdog compiled in with `define FPU_ARB_TIMEOUT_EN.
module fpu_arith_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [1:0]  req0_rmode,
  input  logic [79:0] req0_a,
  input  logic [79:0] req0_b,
  input  logic [63:0] req0_aux,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [1:0]  req1_rmode,
  input  logic [79:0] req1_a,
  input  logic [79:0] req1_b,
  input  logic [63:0] req1_aux,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [79:0] rsp_result,
  output logic [63:0] rsp_aux,
  output logic [3:0]  rsp_cc,
  output logic [5:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [3:0]  au_operation,
  output logic [1:0]  au_rounding_mode,
  output logic        au_enable,
  output logic [79:0] au_operand_a,
  output logic [79:0] au_operand_b,
  output logic [15:0] au_int16_in,
  output logic [31:0] au_int32_in,
  output logic [31:0] au_fp32_in,
  output logic [63:0] au_fp64_in,
  input  logic [79:0] au_result,
  input  logic [15:0] au_int16_out,
  input  logic [31:0] au_int32_out,
  input  logic [31:0] au_fp32_out,
  input  logic [63:0] au_fp64_out,
  input  logic        au_done,
  input  logic [3:0]  au_cc,
  input  logic [5:0]  au_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic [3:0]  hold_op_reg;
  logic [1:0]  hold_rmode_reg;
  logic [79:0] hold_a_reg, hold_b_reg;
  logic [63:0] hold_aux_reg;
  logic        hold_id_reg;
  logic [79:0] rsp_result_reg;
  logic [63:0] rsp_aux_reg;
  logic [3:0]  rsp_cc_reg;
  logic [5:0]  rsp_flags_reg;
  logic        grant0, grant1, accept, timeout_hit;
  logic [63:0] aux_capture;

  // Tie goes to whoever did not win last; last_grant resets to 1 so req0 wins first.
  assign grant0 = req0_valid & (~req1_valid | last_grant_reg);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_reg);
  assign req0_ready = reset & (state_reg == IDLE) & grant0;
  assign req1_ready = reset & (state_reg == IDLE) & grant1;
  assign accept = req0_ready | req1_ready;

  assign busy             = (state_reg != IDLE);
  assign rsp_valid        = (state_reg == RESP);
  assign au_enable        = (state_reg == ISSUE);
  assign au_operation     = hold_op_reg;
  assign au_rounding_mode = hold_rmode_reg;
  assign au_operand_a     = hold_a_reg;
  assign au_operand_b     = hold_b_reg;
  assign au_int16_in      = hold_aux_reg[15:0];
  assign au_int32_in      = hold_aux_reg[31:0];
  assign au_fp32_in       = hold_aux_reg[31:0];
  assign au_fp64_in       = hold_aux_reg;
  assign rsp_id           = hold_id_reg;
  assign rsp_result       = rsp_result_reg;
  assign rsp_aux          = rsp_aux_reg;
  assign rsp_cc           = rsp_cc_reg;
  assign rsp_flags        = rsp_flags_reg;

  always_comb begin
    aux_capture = '0;
    case (hold_op_reg)
      4'd6:    aux_capture = {{48{au_int16_out[15]}}, au_int16_out};
      4'd7:    aux_capture = {{32{au_int32_out[31]}}, au_int32_out};
      4'd10:   aux_capture = {32'h0, au_fp32_out};
      4'd11:   aux_capture = au_fp64_out;
      default: aux_capture = '0;
    endcase
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;
  logic          rsp_timeout_reg;

  // done has priority over an expiring count
  assign timeout_hit = (state_reg == WAIT) & ~au_done &
                       (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE)
        wait_cnt_reg <= '0;
      else if (state_reg == WAIT)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (state_reg == WAIT && au_done)
        rsp_timeout_reg <= 1'b0;
      else if (timeout_hit)
        rsp_timeout_reg <= 1'b1;
    end
  end
`else
  // Without the watchdog the parameter has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (au_done || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      hold_op_reg    <= '0;
      hold_rmode_reg <= '0;
      hold_a_reg     <= '0;
      hold_b_reg     <= '0;
      hold_aux_reg   <= '0;
      hold_id_reg    <= 1'b0;
      rsp_result_reg <= '0;
      rsp_aux_reg    <= '0;
      rsp_cc_reg     <= '0;
      rsp_flags_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        hold_id_reg    <= req1_ready;
        hold_op_reg    <= req1_ready ? req1_op    : req0_op;
        hold_rmode_reg <= req1_ready ? req1_rmode : req0_rmode;
        hold_a_reg     <= req1_ready ? req1_a     : req0_a;
        hold_b_reg     <= req1_ready ? req1_b     : req0_b;
        hold_aux_reg   <= req1_ready ? req1_aux   : req0_aux;
      end
      if (state_reg == WAIT && au_done) begin
        rsp_result_reg <= au_result;
        rsp_aux_reg    <= aux_capture;
        rsp_cc_reg     <= au_cc;
        rsp_flags_reg  <= au_flags;
      end else if (timeout_hit) begin
        rsp_result_reg <= '0;
        rsp_aux_reg    <= '0;
        rsp_cc_reg     <= 4'b0001;
        rsp_flags_reg  <= 6'b100000;
      end
      if (state_reg == RESP && rsp_ready)
        last_grant_reg <= hold_id_reg;
    end
  end

endmodule

// File: doc/fpu_arith_arbiter.md
# fpu_arith_arbiter

- Shares one FPU arithmetic unit between two requesters: requester 0 is the FPU core's instruction sequencer, requester 1 is the microcode or transcendental sequencer.
- Arbitrates round-robin, latches the winning request, and issues a one-cycle enable to the unit with operands held stable.
- Waits for done, captures result, condition codes and exception flags, then returns a response with a ready/valid handshake.
- Sits between the FPU core control logic and the arithmetic-unit wrapper.

## Interface
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before forced abort; only used when the timeout watchdog is compiled in.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- reqN_valid  in  1  request N (N=0,1) valid; held until accepted.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_op  in  4  operation code 0–15, passed through unchanged.
- reqN_rmode  in  2  rounding mode.
- reqN_a, reqN_b  in  80  FP80 operands.
- reqN_aux  in  64  integer/FP32/FP64 source.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  the addressed requester accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  80  FP80 result.
- rsp_aux  out  64  integer/FP32/FP64 result.
- rsp_cc  out  4  {less, equal, greater, unordered}.
- rsp_flags  out  6  {invalid, denormal, zero_divide, overflow, underflow, inexact}.
- rsp_timeout  out  1  response was produced by the watchdog.
- busy  out  1  state is not IDLE.
- au_operation  out  4; au_rounding_mode  out  2; au_enable  out  1; au_operand_a, au_operand_b  out  80.
- au_int16_in  out  16  = aux[15:0]; au_int32_in  out  32  = aux[31:0]; au_fp32_in  out  32  = aux[31:0]; au_fp64_in  out  64  = aux.
- au_result  in  80; au_int16_out  in  16; au_int32_out  in  32; au_fp32_out  in  32; au_fp64_out  in  64.
- au_done  in  1; au_cc  in  4; au_flags  in  6  (same bit order as rsp_cc / rsp_flags).

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Grant logic: a single valid requester is granted; if both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) & grantN, combinational.
  - On valid&ready: latch op, rmode, a, b, aux and id into hold registers; go to ISSUE.
- ISSUE: au_enable=1 for exactly one cycle; go to WAIT. au_* inputs are driven from the hold registers from ISSUE through WAIT.
- WAIT:
  - au_done is sampled only in WAIT. Units assert done no earlier than the cycle after enable.
  - On au_done, capture into the rsp_* registers:
    - rsp_result ← au_result; rsp_cc ← au_cc; rsp_flags ← au_flags.
    - rsp_aux: op 6 → sign-extended au_int16_out; op 7 → sign-extended au_int32_out; op 10 → zero-extended au_fp32_out; op 11 → au_fp64_out; otherwise 0.
  - Then go to RESP.
- RESP: rsp_valid=1; registers are held stable until rsp_ready. On rsp_ready, set last_grant ← rsp_id and go to IDLE.
- Requesters must not drop valid before ready. A valid that is dropped early is simply not granted.
- Reset (synchronous, reset==0):
  - State IDLE.
  - Outputs cleared: au_enable=0, rsp_valid=0, rsp_* and au_* = 0, busy=0, reqN_ready=0.
  - last_grant=1, so requester 0 wins the first tie; watchdog counter 0.
- Reset mid-operation discards the in-flight op with no response. The arithmetic unit shares the same reset.

## Timing
- Accept in cycle T; au_enable high in T+1; WAIT from T+2.
- If au_done is asserted in cycle T+2+k, rsp_valid rises in T+3+k.
- Minimum issue-to-issue interval: 4 cycles (accept, issue, one WAIT cycle, one RESP cycle with rsp_ready=1).
- No new request is accepted while busy. Only one op is outstanding.
- Arbitration decisions are made only in IDLE. A request arriving during RESP waits until the IDLE cycle that follows.

## Configuration
- FPU_ARB_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs during WAIT.
  - If it reaches TIMEOUT_CYCLES without au_done: capture rsp_result=0, rsp_aux=0, rsp_cc=4'b0001 (unordered), rsp_flags=6'b100000 (invalid), rsp_timeout=1; go to RESP.
  - The counter clears on entry to WAIT.
  - If au_done arrives in the same cycle the count expires, done wins.
- FPU_ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely; rsp_timeout is tied to 0; TIMEOUT_CYCLES is ignored.

## Test plan
- Single op: req0 op=2 (MUL), a=2.0, b=3.0, unit done 5 cycles after enable → one au_enable pulse, rsp_valid 7 cycles after accept, rsp_id=0, rsp_result=6.0 FP80, flags=0.
- Tie: req0 and req1 both valid from reset → req0 granted first, req1 second, req0 third; rsp_id sequence 0,1,0.
- Conversion: req1 op=6 with the unit returning au_int16_out=16'hFFFE → rsp_aux=64'hFFFF_FFFF_FFFF_FFFE. Repeat with op=10 and au_fp32_out=32'h3F800000 → rsp_aux=64'h0000_0000_3F80_0000.
- Backpressure: hold rsp_ready=0 for 10 cycles while req1 is valid → rsp_* stable, reqN_ready=0 throughout; after rsp_ready=1, req1 is accepted 1 cycle later.
- Reset mid-WAIT: reset=0 for 1 cycle → next cycle busy=0, rsp_valid=0, au_enable=0; no response for the discarded op; a later tie grants req0.
- Timeout (FPU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): au_done never asserted → rsp_valid after 16 WAIT cycles with rsp_timeout=1, rsp_flags=6'b100000.
